cvxif_multi_coprocessor: RTL and testbench
==========================================

Name: cvxif_multi_coprocessor

Overview:
- Parametrised next-generation CV-X-IF example coprocessor.
- Accepts custom-opcode add/sub instructions from the CPU issue interface and buffers up to NbEntries in flight.
- Tracks per-id commit/kill, executes each entry with fixed or data-dependent latency, and returns results through a ready/valid result channel with backpressure.
- Sits between the core's CV-X-IF request/response ports and nothing else (stand-alone accelerator).

Parameters:
- XLEN, 32, operand/result width.
- NbRs, 2, source operands used (2 or 3); rs3 is added only when 3.
- IdWidth, 3, instruction id width.
- NbEntries, 4, in-flight buffer depth (1..16).
- CustomOpcode, 7'b1111011, accepted opcode.
- LatMode, 0, 0 = fixed latency FixedLat; 1 = data-dependent latency result[3:0].
- FixedLat, 2, execute cycles after commit when LatMode=0 (0..15).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset.
- issue_valid_i  in  1  issue request valid.
- issue_ready_o  out  1  free entry available.
- issue_id_i  in  IdWidth  instruction id.
- issue_instr_i  in  32  instruction word.
- issue_rs_i  in  NbRs*XLEN  operands, rs1 in LSBs.
- issue_accept_o  out  1  instruction accepted (valid when issue_valid_i).
- issue_writeback_o  out  1  accepted instruction will write rd.
- commit_valid_i  in  1  commit strobe.
- commit_id_i  in  IdWidth  committed id.
- commit_kill_i  in  1  1 = kill, 0 = commit.
- result_valid_o  out  1  result valid.
- result_ready_i  in  1  core accepts result.
- result_id_o  out  IdWidth  result id.
- result_data_o  out  XLEN  result data.
- result_rd_o  out  5  destination register, instr[11:7].
- result_we_o  out  1  register write enable.

Behaviour:
- Interface: one clock clk_i; reset rst_i is synchronous, active-high. On reset all entries are FREE, result_valid_o=0, and result_id_o/data/rd/we read 0. issue_ready_o reads 1 in the cycle after reset deasserts.
- Decode (combinational, same cycle), with opcode==CustomOpcode:
  - funct3=000: ADD, rs1+rs2(+rs3), writeback=1.
  - funct3=001: SUB, rs1-rs2(-rs3), writeback=1.
  - funct3=010: ADD, writeback=0.
  - Anything else: accept=0, writeback=0.
- Duplicate id: an instruction whose id matches a non-FREE entry gets accept=0.
- Arithmetic is modulo 2^XLEN; no exceptions are raised.
- Issue handshake occurs when issue_valid_i & issue_ready_o. Accepted instructions are allocated into the lowest-index FREE entry, state WAIT_COMMIT, with the result computed at allocation. Rejected instructions complete the handshake but allocate nothing.
- issue_ready_o = at least one FREE entry, registered from the previous cycle's state. It deasserts the cycle after the last entry fills.
- Per-entry states FREE -> WAIT_COMMIT -> EXEC -> DONE -> FREE:
  - WAIT_COMMIT, commit_valid_i with matching id, kill=1: -> FREE.
  - WAIT_COMMIT, commit_valid_i with matching id, kill=0: -> EXEC, counter loaded with latency (FixedLat or result[3:0]).
  - EXEC: counter decrements each cycle; at 0 -> DONE. Latency 0 goes to DONE the cycle after commit.
  - DONE: -> FREE on result handshake (result_valid_o & result_ready_i).
- Commits whose id matches no WAIT_COMMIT entry are ignored. This includes ids in EXEC/DONE and unknown ids.
- A commit in the same cycle as issue of the same id applies to the newly allocated entry.
- Result select: lowest-index DONE entry. Once result_valid_o=1, id/data/rd/we hold stable until the handshake; a newly DONE lower-index entry does not preempt.
- result_we_o = entry writeback bit, gated by result_valid_o.
- Simultaneous events are legal and all take effect in the same cycle: issue allocation, commit/kill of another entry, and result free. An entry freed by the result handshake is not reusable until the next cycle.
- Full buffer: issue_valid_i is held off by issue_ready_o=0; nothing is dropped.
- Reset mid-operation discards all entries; no result is emitted for them.

Test Plan:
- Issue id=1 ADD rs1=5 rs2=7, commit id=1 kill=0, LatMode=0, FixedLat=2, result_ready_i=1 -> result_valid_o exactly 3 cycles after commit, data=12, rd=instr[11:7], we=1.
- Issue id=2 funct3=011 -> issue_accept_o=0, writeback=0, no result ever. Then issue id=3 and kill id=3 -> entry freed, no result, issue_ready_o stays 1.
- Fill 4 entries (ids 0..3) without commit -> issue_ready_o=0 the following cycle. Kill id=2 -> issue_ready_o=1 the next cycle; a new id=5 lands in entry 2.
- LatMode=1, commit ids 0 (rs 3+4, data 7) and 1 (rs 1+1, data 2) in the same cycle -> id 1 result at +3 cycles, id 0 result at +8 cycles.
- Two DONE entries with result_ready_i=0 for 5 cycles -> outputs stable on the lowest index. Raise ready -> two consecutive handshakes, lowest index first.
- Assert rst_i with 3 entries in EXEC -> next cycle all outputs 0 and issue_ready_o=1; no stale result appears afterwards.

Source files
------------

// File: rtl/cvxif_multi_coprocessor.sv
// cvxif_multi_coprocessor: CV-X-IF example coprocessor with a small in-flight buffer.
// Accepts custom-opcode ADD/SUB instructions from the issue port and holds each one
// in a buffer entry. An entry waits for its commit or kill, then runs for a fixed or
// data-dependent number of cycles. Finished results are returned on a ready/valid
// channel, lowest entry index first.
// Ports:
//   clk_i, rst_i           clock, synchronous active-high reset
//   issue_*                issue request (valid/ready) with accept/writeback decode
//   commit_*               commit strobe carrying an id and a kill flag
//   result_*               result channel (valid/ready) with id, data, rd and we
module cvxif_multi_coprocessor #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned NbRs         = 2,
    parameter int unsigned IdWidth      = 3,
    parameter int unsigned NbEntries    = 4,
    parameter logic [6:0]  CustomOpcode = 7'b1111011,
    parameter int unsigned LatMode      = 0,
    parameter int unsigned FixedLat     = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 issue_valid_i,
    output logic                 issue_ready_o,
    input  logic [IdWidth-1:0]   issue_id_i,
    input  logic [31:0]          issue_instr_i,
    input  logic [NbRs*XLEN-1:0] issue_rs_i,
    output logic                 issue_accept_o,
    output logic                 issue_writeback_o,
    input  logic                 commit_valid_i,
    input  logic [IdWidth-1:0]   commit_id_i,
    input  logic                 commit_kill_i,
    output logic                 result_valid_o,
    input  logic                 result_ready_i,
    output logic [IdWidth-1:0]   result_id_o,
    output logic [XLEN-1:0]      result_data_o,
    output logic [4:0]           result_rd_o,
    output logic                 result_we_o
);
    localparam int unsigned IdxW = (NbEntries > 1) ? $clog2(NbEntries) : 1;

    typedef enum logic [1:0] {FREE, WAIT_COMMIT, EXEC, DONE} ent_state_e;

    typedef struct packed {
        logic [IdWidth-1:0] id;
        logic [XLEN-1:0]    data;
        logic [4:0]         rd;
        logic               we;
    } ent_t;

    ent_state_e state_q [NbEntries];
    ent_state_e state_d [NbEntries];
    ent_t       ent_q   [NbEntries];
    ent_t       ent_d   [NbEntries];
    logic [3:0] cnt_q   [NbEntries];
    logic [3:0] cnt_d   [NbEntries];

    function automatic logic [3:0] lat_of(input logic [XLEN-1:0] d);
        return (LatMode != 0) ? d[3:0] : 4'(FixedLat);
    endfunction

    // ---------------- decode ----------------
    logic [XLEN-1:0] rs1, rs2, rs3, new_data;
    logic [2:0]      funct3;
    logic            op_ok, dup;
    ent_t            new_ent;
    logic [3:0]      new_lat;
    logic            unused_instr;

    assign rs1 = issue_rs_i[XLEN-1:0];
    assign rs2 = issue_rs_i[2*XLEN-1:XLEN];
    generate
        if (NbRs >= 3) begin : g_rs3
            assign rs3 = issue_rs_i[3*XLEN-1:2*XLEN];
        end else begin : g_no_rs3
            assign rs3 = '0;
        end
    endgenerate

    assign unused_instr = ^issue_instr_i[31:15];
    assign funct3       = issue_instr_i[14:12];
    assign op_ok        = (issue_instr_i[6:0] == CustomOpcode) &&
                          (funct3 inside {3'b000, 3'b001, 3'b010});
    assign new_data     = (funct3 == 3'b001) ? (rs1 - rs2 - rs3) : (rs1 + rs2 + rs3);
    assign new_lat      = lat_of(new_data);

    assign issue_accept_o    = op_ok & ~dup;
    assign issue_writeback_o = issue_accept_o & (funct3 != 3'b010);

    always_comb begin
        new_ent      = '0;
        new_ent.id   = issue_id_i;
        new_ent.data = new_data;
        new_ent.rd   = issue_instr_i[11:7];
        new_ent.we   = (funct3 != 3'b010);
    end

    // ---------------- entry scan ----------------
    // Descending loop so the last hit is the lowest index.
    logic            any_free, any_done;
    logic [IdxW-1:0] alloc_idx, done_idx, sel_idx;

    always_comb begin
        any_free  = 1'b0;
        any_done  = 1'b0;
        dup       = 1'b0;
        alloc_idx = '0;
        done_idx  = '0;
        for (int i = int'(NbEntries) - 1; i >= 0; i--) begin
            if (state_q[i] == FREE) begin
                any_free  = 1'b1;
                alloc_idx = IdxW'(i);
            end
            if (state_q[i] == DONE) begin
                any_done = 1'b1;
                done_idx = IdxW'(i);
            end
            if (state_q[i] != FREE && ent_q[i].id == issue_id_i) dup = 1'b1;
        end
    end

    // ---------------- result channel ----------------
    // Once a result is offered it is pinned until taken, so a lower-index entry
    // finishing later cannot swap the payload under a stalled consumer.
    logic            lock_q;
    logic [IdxW-1:0] lock_idx_q;
    logic            result_pop;

    assign sel_idx        = lock_q ? lock_idx_q : done_idx;
    assign result_valid_o = lock_q | any_done;
    assign result_pop     = result_valid_o & result_ready_i;
    assign result_id_o    = result_valid_o ? ent_q[sel_idx].id   : '0;
    assign result_data_o  = result_valid_o ? ent_q[sel_idx].data : '0;
    assign result_rd_o    = result_valid_o ? ent_q[sel_idx].rd   : '0;
    assign result_we_o    = result_valid_o & ent_q[sel_idx].we;

    // ---------------- per-entry next state ----------------
    logic issue_ready_q, issue_fire, free_next;

    assign issue_ready_o = issue_ready_q;
    assign issue_fire    = issue_valid_i & issue_ready_q & issue_accept_o & any_free;

    // On commit, an entry with latency L spends L cycles in EXEC (cnt counts
    // L-1 .. 0); L=0 skips EXEC and is DONE the next cycle.
    always_comb begin
        for (int i = 0; i < int'(NbEntries); i++) begin
            state_d[i] = state_q[i];
            ent_d[i]   = ent_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                FREE: begin
                    if (issue_fire && alloc_idx == IdxW'(i)) begin
                        ent_d[i] = new_ent;
                        if (commit_valid_i && commit_id_i == issue_id_i) begin
                            // Same-cycle commit targets the new entry; a kill leaves it FREE.
                            if (!commit_kill_i) begin
                                state_d[i] = (new_lat == 4'd0) ? DONE : EXEC;
                                cnt_d[i]   = new_lat - 4'd1;
                            end
                        end else begin
                            state_d[i] = WAIT_COMMIT;
                        end
                    end
                end
                WAIT_COMMIT: begin
                    if (commit_valid_i && commit_id_i == ent_q[i].id) begin
                        if (commit_kill_i) begin
                            state_d[i] = FREE;
                        end else begin
                            state_d[i] = (lat_of(ent_q[i].data) == 4'd0) ? DONE : EXEC;
                            cnt_d[i]   = lat_of(ent_q[i].data) - 4'd1;
                        end
                    end
                end
                EXEC: begin
                    if (cnt_q[i] == 4'd0) state_d[i] = DONE;
                    else                  cnt_d[i]   = cnt_q[i] - 4'd1;
                end
                DONE: begin
                    if (result_pop && sel_idx == IdxW'(i)) state_d[i] = FREE;
                end
                default: state_d[i] = FREE;
            endcase
        end
    end

    // Ready is a registered view of next-cycle occupancy, so it drops in the
    // cycle right after the last free entry is taken.
    always_comb begin
        free_next = 1'b0;
        for (int i = 0; i < int'(NbEntries); i++) begin
            if (state_d[i] == FREE) free_next = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(NbEntries); i++) begin
                state_q[i] <= FREE;
                ent_q[i]   <= '0;
                cnt_q[i]   <= '0;
            end
            lock_q        <= 1'b0;
            lock_idx_q    <= '0;
            issue_ready_q <= 1'b1;
        end else begin
            for (int i = 0; i < int'(NbEntries); i++) begin
                state_q[i] <= state_d[i];
                ent_q[i]   <= ent_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            lock_q        <= result_valid_o & ~result_ready_i;
            lock_idx_q    <= sel_idx;
            issue_ready_q <= free_next;
        end
    end
endmodule

// File: tb/tb_cvxif_multi_coprocessor.sv
// Directed bench for cvxif_multi_coprocessor. dut0 uses fixed latency 2,
// dut1 uses data-dependent latency; both share the same stimulus.
module tb_cvxif_multi_coprocessor;
    logic        clk;
    logic        rst;
    logic        issue_valid;
    logic [2:0]  issue_id;
    logic [31:0] issue_instr;
    logic [63:0] issue_rs;
    logic        commit_valid;
    logic [2:0]  commit_id;
    logic        commit_kill;
    logic        result_ready;

    logic        r0_iready, r0_accept, r0_wb, r0_valid, r0_we;
    logic [2:0]  r0_id;
    logic [31:0] r0_data;
    logic [4:0]  r0_rd;
    logic        r1_iready, r1_accept, r1_wb, r1_valid, r1_we;
    logic [2:0]  r1_id;
    logic [31:0] r1_data;
    logic [4:0]  r1_rd;

    int n_pass  = 0;
    int n_total = 0;

    cvxif_multi_coprocessor #(.LatMode(0), .FixedLat(2)) dut0 (
        .clk_i(clk), .rst_i(rst),
        .issue_valid_i(issue_valid), .issue_ready_o(r0_iready),
        .issue_id_i(issue_id), .issue_instr_i(issue_instr), .issue_rs_i(issue_rs),
        .issue_accept_o(r0_accept), .issue_writeback_o(r0_wb),
        .commit_valid_i(commit_valid), .commit_id_i(commit_id), .commit_kill_i(commit_kill),
        .result_valid_o(r0_valid), .result_ready_i(result_ready),
        .result_id_o(r0_id), .result_data_o(r0_data), .result_rd_o(r0_rd), .result_we_o(r0_we)
    );

    cvxif_multi_coprocessor #(.LatMode(1)) dut1 (
        .clk_i(clk), .rst_i(rst),
        .issue_valid_i(issue_valid), .issue_ready_o(r1_iready),
        .issue_id_i(issue_id), .issue_instr_i(issue_instr), .issue_rs_i(issue_rs),
        .issue_accept_o(r1_accept), .issue_writeback_o(r1_wb),
        .commit_valid_i(commit_valid), .commit_id_i(commit_id), .commit_kill_i(commit_kill),
        .result_valid_o(r1_valid), .result_ready_i(result_ready),
        .result_id_o(r1_id), .result_data_o(r1_data), .result_rd_o(r1_rd), .result_we_o(r1_we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk(input logic [2:0] f3, input logic [4:0] rd);
        return {17'd0, f3, rd, 7'b1111011};
    endfunction

    task automatic drive_issue(input logic [2:0] id, input logic [31:0] instr,
                               input logic [31:0] a, input logic [31:0] b);
        issue_valid = 1'b1;
        issue_id    = id;
        issue_instr = instr;
        issue_rs    = {b, a};
    endtask

    task automatic drive_commit(input logic [2:0] id, input logic kill);
        commit_valid = 1'b1;
        commit_id    = id;
        commit_kill  = kill;
    endtask

    initial begin
        rst = 1'b1; issue_valid = 1'b0; issue_id = '0; issue_instr = '0; issue_rs = '0;
        commit_valid = 1'b0; commit_id = '0; commit_kill = 1'b0; result_ready = 1'b1;

        // reset state
        tick(); tick(); #1;
        chk("rst_valid", r0_valid, 0);
        chk("rst_data",  r0_data,  0);
        chk("rst_id",    r0_id,    0);
        rst = 1'b0;
        tick(); #1;
        chk("ready_after_rst", r0_iready, 1);

        // ADD 5+7, commit, result 3 cycles later
        drive_issue(3'd1, mk(3'd0, 5'd10), 32'd5, 32'd7); #1;
        chk("add_accept", r0_accept, 1);
        chk("add_wb",     r0_wb,     1);
        tick(); issue_valid = 1'b0;
        drive_commit(3'd1, 1'b0); #1;
        chk("add_c0", r0_valid, 0);
        tick(); commit_valid = 1'b0; #1;
        chk("add_c1", r0_valid, 0);
        tick(); #1;
        chk("add_c2", r0_valid, 0);
        tick(); #1;
        chk("add_c3_valid", r0_valid, 1);
        chk("add_id",       r0_id,    1);
        chk("add_data",     r0_data,  12);
        chk("add_rd",       r0_rd,    10);
        chk("add_we",       r0_we,    1);
        tick(); #1;
        chk("add_popped", r0_valid, 0);

        // unsupported funct3, then issue + kill
        drive_issue(3'd2, mk(3'd3, 5'd4), 32'd1, 32'd1); #1;
        chk("bad_accept", r0_accept, 0);
        chk("bad_wb",     r0_wb,     0);
        tick();
        drive_issue(3'd3, mk(3'd0, 5'd3), 32'd1, 32'd1); #1;
        chk("id3_accept", r0_accept, 1);
        tick(); issue_valid = 1'b0;
        drive_commit(3'd3, 1'b1);
        tick(); commit_valid = 1'b0; #1;
        chk("kill_ready", r0_iready, 1);
        tick(); tick(); tick(); #1;
        chk("kill_no_result", r0_valid, 0);

        // fill all four entries
        drive_issue(3'd0, mk(3'd1, 5'd1), 32'd3, 32'd10);          tick();
        drive_issue(3'd1, mk(3'd0, 5'd2), 32'hFFFF_FFFF, 32'd2);   tick();
        drive_issue(3'd2, mk(3'd0, 5'd3), 32'd1, 32'd1);           tick();
        drive_issue(3'd3, mk(3'd2, 5'd4), 32'd1, 32'd2); #1;
        chk("fill_last_ready", r0_iready, 1);
        chk("nowb_accept",     r0_accept, 1);
        chk("nowb_wb",         r0_wb,     0);
        tick(); issue_valid = 1'b0; #1;
        chk("full_ready", r0_iready, 0);
        drive_issue(3'd1, mk(3'd0, 5'd2), 32'd0, 32'd0); #1;
        chk("dup_accept", r0_accept, 0);
        issue_valid = 1'b0;
        drive_commit(3'd2, 1'b1);
        tick(); commit_valid = 1'b0; #1;
        chk("kill2_ready", r0_iready, 1);
        drive_issue(3'd5, mk(3'd0, 5'd5), 32'd20, 32'd22); #1;
        chk("id5_accept", r0_accept, 1);
        tick(); issue_valid = 1'b0; #1;
        chk("refull_ready", r0_iready, 0);

        // backpressure: id5 (entry 2) offered first, id0 (entry 0) must not preempt
        result_ready = 1'b0;
        drive_commit(3'd5, 1'b0); tick();
        drive_commit(3'd0, 1'b0); tick();
        commit_valid = 1'b0; tick(); #1;
        chk("bp_valid", r0_valid, 1);
        chk("bp_id",    r0_id,    5);
        chk("bp_data",  r0_data,  42);
        for (int k = 0; k < 5; k++) begin
            tick(); #1;
            chk("bp_hold_id",   r0_id,   5);
            chk("bp_hold_data", r0_data, 42);
        end
        result_ready = 1'b1; #1;
        chk("bp_release_id", r0_id, 5);
        tick(); #1;
        chk("sub_valid", r0_valid, 1);
        chk("sub_id",    r0_id,    0);
        chk("sub_data",  r0_data,  32'hFFFF_FFF9);
        chk("sub_rd",    r0_rd,    1);
        chk("sub_we",    r0_we,    1);
        tick(); #1;
        chk("bp_drained", r0_valid, 0);

        // wrap-around add and writeback=0 entry
        drive_commit(3'd1, 1'b0); tick();
        drive_commit(3'd3, 1'b0); tick();
        commit_valid = 1'b0; tick(); #1;
        chk("wrap_id",   r0_id,   1);
        chk("wrap_data", r0_data, 1);
        tick(); #1;
        chk("nowb_valid", r0_valid, 1);
        chk("nowb_id",    r0_id,    3);
        chk("nowb_data",  r0_data,  3);
        chk("nowb_rd",    r0_rd,    4);
        chk("nowb_we",    r0_we,    0);
        tick(); #1;
        chk("nowb_popped", r0_valid, 0);

        // data-dependent latency on dut1
        rst = 1'b1; tick(); rst = 1'b0; tick();
        drive_issue(3'd0, mk(3'd0, 5'd6), 32'd3, 32'd4); tick();
        drive_issue(3'd1, mk(3'd0, 5'd7), 32'd1, 32'd1); tick();
        issue_valid = 1'b0;
        drive_commit(3'd0, 1'b0); #1;
        chk("lm_c0", r1_valid, 0);
        tick(); drive_commit(3'd1, 1'b0);
        tick(); commit_valid = 1'b0;
        tick(); #1;
        chk("lm_c3", r1_valid, 0);
        tick(); #1;
        chk("lm_id1_valid", r1_valid, 1);
        chk("lm_id1_id",    r1_id,    1);
        chk("lm_id1_data",  r1_data,  2);
        tick(); #1;
        chk("lm_c5", r1_valid, 0);
        tick(); tick(); #1;
        chk("lm_c7", r1_valid, 0);
        tick(); #1;
        chk("lm_id0_valid", r1_valid, 1);
        chk("lm_id0_id",    r1_id,    0);
        chk("lm_id0_data",  r1_data,  7);
        tick(); #1;
        chk("lm_c9", r1_valid, 0);

        // issue with same-cycle commit, then reset mid-flight
        drive_issue(3'd4, mk(3'd0, 5'd8), 32'd15, 32'd0); drive_commit(3'd4, 1'b0); tick();
        drive_issue(3'd5, mk(3'd0, 5'd8), 32'd15, 32'd0); drive_commit(3'd5, 1'b0); tick();
        drive_issue(3'd6, mk(3'd0, 5'd8), 32'd15, 32'd0); drive_commit(3'd6, 1'b0); tick();
        issue_valid = 1'b0; commit_valid = 1'b0; #1;
        chk("samecyc_valid", r0_valid, 1);
        chk("samecyc_id",    r0_id,    4);
        chk("samecyc_data",  r0_data,  15);
        chk("exec_busy",     r1_valid, 0);
        rst = 1'b1;
        tick(); #1;
        chk("mid_rst_valid", r1_valid,  0);
        chk("mid_rst_data",  r1_data,   0);
        chk("mid_rst_id",    r1_id,     0);
        chk("mid_rst_ready", r1_iready, 1);
        chk("mid_rst_r0",    r0_valid,  0);
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick(); #1;
            chk("no_stale", {r0_valid, r1_valid}, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
